display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller that shares one `display` 7-segment decoder across N_DIGITS common-anode/cathode digits. Holds a frame buffer of BCD/hex nibbles and accepts new values through a load/ready handshake. Applies new values only at frame boundaries, so no digit is ever shown with mixed old/new data. Sits between application logic (counters, FSM outputs) and the board's segment/anode pins.

Parameters:
N_DIGITS, 4, number of multiplexed digits (2..8)
SCAN_DIV, 50000, clock cycles per digit slot, including the blank cycle (min 2)
AN_ACTIVE_LOW, 1, 1: anode enable driven low-active; 0: high-active

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
load  in  1  request to load new frame
valor  in  4*N_DIGITS  nibble per digit; digit k = valor[4k+3:4k], digit 0 rightmost
dp_in  in  N_DIGITS  decimal point per digit, latched with valor
ready  out  1  controller can accept load
an  out  N_DIGITS  digit enables (polarity per AN_ACTIVE_LOW)
a,b,c,d,e,f,g  out  1 each  segment outputs from shared `display` decoder
dp  out  1  decimal point of currently shown digit

Behaviour:
- Reset (sync, active-high), all values held while reset=1:
  - idx=0, prescaler=0, state=BLANK, active buffer=0, shadow=0, pend=0.
  - ready=1; an=all off; segments show decode of nibble 0; dp=0.
- FSM per slot:
  - BLANK: exactly 1 cycle, an all off (anti-ghosting); next state SHOW.
  - SHOW: SCAN_DIV-1 cycles; an enables digit idx only.
  - Slot end = SHOW with prescaler==SCAN_DIV-2 -> prescaler=0, state=BLANK, idx=idx+1, wrapping N_DIGITS-1 -> 0.
- Outputs: an is registered. Segments are the combinational decode of active[idx]; dp=active_dp[idx].
- Handshake:
  - load && ready on edge -> shadow<=valor, shadow_dp<=dp_in, pend<=1; ready=!pend, low from the next cycle.
  - load while ready=0 is ignored; shadow is not overwritten.
- Frame commit: at the slot end where idx==N_DIGITS-1 and pend==1 -> active<=shadow, pend<=0. ready returns high the following cycle. New data is first visible on digit 0 of the next frame.
- Simultaneous load&&ready on the same cycle as a commit cannot happen (pend=0 there means no commit). A load on the final cycle of a frame is stored but waits for the next frame end.
- Worst-case load-to-visible latency: N_DIGITS*SCAN_DIV + 1 cycles.
- Reset mid-frame: pending shadow is discarded; scan restarts at digit 0 with BLANK.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: for the committed frame, digits above the most significant nonzero nibble are forced off (an inactive during their SHOW state). Digit 0 is always shown. dp_in=1 on a digit prevents blanking of that digit and all lower digits. The blank mask is computed at commit and registered.
- Undefined: all digits always shown; no mask logic.

Decomposition:
- Package display_pkg:
  - constants AN_OFF/AN_ON helpers and the MAX_DIGITS=8 bound.
  - typedef enum logic {BLANK, SHOW} scan_state_t.
  - typedef logic [3:0] nibble_t.
- Sub-module: one instance of the existing `display` decoder (data -> a..g, dp).
- Prescaler, FSM and buffers stay in display_scan_ctrl.

Test Plan:
(Sim parameters N_DIGITS=4, SCAN_DIV=4, AN_ACTIVE_LOW=1.)
- Reset released -> ready=1. First slot: an=1111 for 1 cycle, then 1110 for 3 cycles; segments = decode of 0. Then 1111, then 1101, and so on; wrap to 1110 after digit 3.
- Pulse load with valor=16'h4321, dp_in=4'b0010 mid-frame -> ready=0 next cycle. Digits keep 0 until frame end; next frame shows 1,2 (dp=1),3,4 on digits 0..3; ready=1 one cycle after commit.
- Pulse load=1 with 16'hAAAA while ready=0 after a pending 16'h1234 -> 1234 is displayed; AAAA never appears.
- Hold load=1 continuously with valor=16'h9876 -> exactly one accept per frame; ready toggles 1->0 after each accept and back to 1 one cycle after each commit.
- Assert reset during SHOW of digit 2 with a load pending -> an=1111; the next frame shows 0s; ready=1.
- With LEADING_ZERO_BLANK_EN, valor=16'h0050 -> digits 2,3 never enabled; digits 0,1 show 0,5. With dp_in=4'b1000, all four digits are shown.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and anode-level helpers for the multiplexed 7-segment scan controller.
package display_pkg;

    localparam int MAX_DIGITS = 8;

    typedef enum logic {BLANK, SHOW} scan_state_t;

    typedef logic [3:0] nibble_t;

    function automatic logic an_on(input logic active_low);
        return !active_low;
    endfunction

    function automatic logic an_off(input logic active_low);
        return active_low;
    endfunction

endpackage

// File: rtl/display.sv
// Hex nibble to 7-segment decoder; segments are active-high (1 = lit), dp passes through.
module display
    import display_pkg::*;
(
    input  logic [3:0] data,
    input  logic       dp_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       dp
);

    logic [6:0] seg;

    always_comb begin
        seg = 7'b0000000;
        case (nibble_t'(data))
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b0011111;
            4'hC: seg = 7'b1001110;
            4'hD: seg = 7'b0111101;
            4'hE: seg = 7'b1001111;
            4'hF: seg = 7'b1000111;
            default: seg = 7'b0000000;
        endcase
    end

    assign {a, b, c, d, e, f, g} = seg;
    assign dp = dp_in;

endmodule

// File: rtl/display_scan_ctrl.sv
// Frame-buffered digit scanner sharing one decoder; new frames commit only at frame end.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits of each committed frame.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int SCAN_DIV      = 50000,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] valor,
    input  logic [N_DIGITS-1:0]   dp_in,
    output logic                  ready,
    output logic [N_DIGITS-1:0]   an,
    output logic                  a,
    output logic                  b,
    output logic                  c,
    output logic                  d,
    output logic                  e,
    output logic                  f,
    output logic                  g,
    output logic                  dp
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV - 1) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    scan_state_t            state_reg, state_next;
    logic [PRE_W-1:0]       prescaler_reg, prescaler_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [4*N_DIGITS-1:0]  active_reg, shadow_reg;
    logic [N_DIGITS-1:0]    active_dp_reg, shadow_dp_reg;
    logic                   pend_reg;
    logic [N_DIGITS-1:0]    an_reg, an_next;
    logic [N_DIGITS-1:0]    keep;
    logic                   slot_end, commit, accept;
    nibble_t                cur_nib;
    logic                   cur_dp;

    always_comb begin
        state_next     = state_reg;
        prescaler_next = prescaler_reg;
        idx_next       = idx_reg;
        slot_end       = 1'b0;
        case (state_reg)
            BLANK: state_next = SHOW;
            SHOW: begin
                if (prescaler_reg == PRE_LAST) begin
                    slot_end       = 1'b1;
                    prescaler_next = '0;
                    state_next     = BLANK;
                    idx_next       = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
                end else begin
                    prescaler_next = prescaler_reg + PRE_W'(1);
                end
            end
            default: state_next = BLANK;
        endcase
    end

    // Commit and accept are exclusive: commit needs pend set, accept needs it clear.
    assign commit = slot_end && (idx_reg == IDX_LAST) && pend_reg;
    assign accept = load && !pend_reg;
    assign ready  = !pend_reg;

`ifdef LEADING_ZERO_BLANK_EN
    logic [N_DIGITS-1:0] keep_next, keep_reg;

    // A digit stays visible if it or any higher digit is nonzero or carries a decimal point.
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_keep
        if (gi == 0) begin : g_lsd
            assign keep_next[gi] = 1'b1;
        end else begin : g_upper
            assign keep_next[gi] = (|shadow_reg[4*N_DIGITS-1:4*gi]) | (|shadow_dp_reg[N_DIGITS-1:gi]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            keep_reg <= N_DIGITS'(1);
        end else if (commit) begin
            keep_reg <= keep_next;
        end
    end

    assign keep = keep_reg;
`else
    assign keep = '1;
`endif

    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_an
        assign an_next[gi] = (state_next == SHOW && idx_next == IDX_W'(gi) && keep[gi])
                             ? an_on(AN_ACTIVE_LOW) : an_off(AN_ACTIVE_LOW);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= BLANK;
            prescaler_reg <= '0;
            idx_reg       <= '0;
            an_reg        <= {N_DIGITS{an_off(AN_ACTIVE_LOW)}};
            active_reg    <= '0;
            active_dp_reg <= '0;
            shadow_reg    <= '0;
            shadow_dp_reg <= '0;
            pend_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            prescaler_reg <= prescaler_next;
            idx_reg       <= idx_next;
            an_reg        <= an_next;
            if (accept) begin
                shadow_reg    <= valor;
                shadow_dp_reg <= dp_in;
                pend_reg      <= 1'b1;
            end else if (commit) begin
                active_reg    <= shadow_reg;
                active_dp_reg <= shadow_dp_reg;
                pend_reg      <= 1'b0;
            end
        end
    end

    assign cur_nib = active_reg[{idx_reg, 2'b00} +: 4];
    assign cur_dp  = active_dp_reg[idx_reg];
    assign an      = an_reg;

    display u_display (
        .data  (cur_nib),
        .dp_in (cur_dp),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .e     (e),
        .f     (f),
        .g     (g),
        .dp    (dp)
    );

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: accepted frames are queued and popped at frame commit.
module tb_display_scan_ctrl;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int FRAME = N * DIV;

    logic        clock = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] valor;
    logic [3:0]  dp_in;
    logic        ready;
    logic [3:0]  an;
    logic        a, b, c, d, e, f, g, dp;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    display_scan_ctrl #(
        .N_DIGITS      (N),
        .SCAN_DIV      (DIV),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .valor (valor),
        .dp_in (dp_in),
        .ready (ready),
        .an    (an),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .e     (e),
        .f     (f),
        .g     (g),
        .dp    (dp)
    );

    logic [19:0] sb_q[$];
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [3:0]  m_keep;
    logic        m_pend;
    int          cyc;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    function automatic logic [3:0] keep_of(input logic [15:0] v, input logic [3:0] dpv);
        logic [3:0] k;
        k = 4'hF;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 1; i < N; i++) begin
            k[i] = 1'b0;
            for (int j = i; j < N; j++) begin
                if (v[j*4 +: 4] != 4'h0 || dpv[j]) k[i] = 1'b1;
            end
        end
`endif
        return k;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int p, slot, sub;
        logic [3:0] exp_an;
        logic [3:0] nib;
        p    = cyc % FRAME;
        slot = p / DIV;
        sub  = p % DIV;
        exp_an = 4'hF;
        if (sub != 0 && m_keep[slot]) exp_an[slot] = 1'b0;
        nib = m_val[slot*4 +: 4];
        check("an", 32'(an), 32'(exp_an));
        check("ready", 32'(ready), 32'(!m_pend));
        check("seg", 32'({a, b, c, d, e, f, g, dp}), 32'({seg7(nib), m_dp[slot]}));
    endtask

    task automatic step();
        logic [19:0] ent;
        int p;
        @(posedge clock);
        if (reset) begin
            cyc    = 0;
            m_pend = 1'b0;
            m_val  = '0;
            m_dp   = '0;
            m_keep = keep_of(16'h0, 4'h0);
            sb_q.delete();
        end else begin
            p = cyc % FRAME;
            if (p == FRAME - 1 && m_pend) begin
                ent    = sb_q.pop_front();
                m_val  = ent[15:0];
                m_dp   = ent[19:16];
                m_keep = keep_of(m_val, m_dp);
                m_pend = 1'b0;
                $display("commit valor=%h dp=%b t=%0t", m_val, m_dp, $time);
            end else if (load && !m_pend) begin
                sb_q.push_back({dp_in, valor});
                m_pend = 1'b1;
                $display("accept valor=%h dp=%b t=%0t", valor, dp_in, $time);
            end
            cyc++;
        end
        @(negedge clock);
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_pos(input int target);
        for (int i = 0; i < FRAME && (cyc % FRAME) != target; i++) step();
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] dpv);
        load  = 1'b1;
        valor = v;
        dp_in = dpv;
        step();
        load  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        valor = '0;
        dp_in = '0;
        cyc   = 0;
        m_pend = 1'b0;
        m_val  = '0;
        m_dp   = '0;
        m_keep = 4'hF;
        run(3);
        reset = 1'b0;
        run(20);

        // Mid-frame load stays hidden until the frame boundary.
        wait_pos(6);
        pulse_load(16'h4321, 4'b0010);
        run(2 * FRAME + 4);

        // Second load while one is pending must be dropped.
        wait_pos(2);
        pulse_load(16'h1234, 4'b0000);
        run(3);
        pulse_load(16'hAAAA, 4'b1111);
        run(2 * FRAME);

        // Load held high: one accept per frame.
        load  = 1'b1;
        valor = 16'h9876;
        dp_in = 4'b0000;
        run(3 * FRAME);
        load  = 1'b0;
        run(FRAME + 2);

        // Reset during digit 2 with a pending load discards it.
        wait_pos(1);
        pulse_load(16'h5555, 4'b0101);
        wait_pos(9);
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        run(FRAME + 4);

        // Load on the last cycle of a frame waits a full extra frame.
        wait_pos(FRAME - 1);
        pulse_load(16'hBEEF, 4'b0001);
        run(2 * FRAME + 2);

        // Leading-zero cases (all digits shown when the blanking option is off).
        pulse_load(16'h0050, 4'b0000);
        run(2 * FRAME + 2);
        pulse_load(16'h0050, 4'b1000);
        run(2 * FRAME + 2);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
